// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer serving a DEPTH x 8 register file plus a
// wait-state configuration register, stretching each access with ready held low.
module apb_slave_regfile #(
    parameter logic [1:0] SEL_ID     = 2'd1,
    parameter int         DEPTH      = 16,
    parameter logic [7:0] WAIT_ADDR  = 8'hFF,
    parameter logic [7:0] WAIT_RESET = 8'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       enable,
    input  logic       write,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ready,
    output logic       err,
    output logic [1:0] state_dbg
);
    // Handshake: a transfer is offered with sel==SEL_ID and enable low (setup),
    // then held with enable high; it completes in the single cycle ready=1, and
    // rdata/err are meaningful only in that cycle.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    wait_reg;
    logic [7:0]    wait_cnt;
    logic [7:0]    lat_addr;
    logic [7:0]    lat_wdata;
    logic          lat_write;
    logic          selected;
    logic          in_range;
    logic          is_wait;
    logic [AW-1:0] mem_idx;

    assign selected  = (sel == SEL_ID);
    assign in_range  = (lat_addr < 8'(DEPTH));
    assign is_wait   = (lat_addr == WAIT_ADDR);
    assign mem_idx   = lat_addr[AW-1:0];
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (selected && !enable) state_next = SETUP;
            SETUP:   state_next = (selected && enable) ? ACCESS : IDLE;
            ACCESS:  if (!selected || wait_cnt == 8'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read data comes from the address latched at setup, never the live bus.
    always_comb begin
        ready = (state == ACCESS) && (wait_cnt == 8'd0) && selected;
        err   = ready && !in_range && !is_wait;
        rdata = 8'd0;
        if (ready && !lat_write) begin
            if (in_range)     rdata = mem[mem_idx];
            else if (is_wait) rdata = wait_reg;
            else              rdata = 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_reg  <= WAIT_RESET;
            wait_cnt  <= 8'd0;
            lat_addr  <= 8'd0;
            lat_wdata <= 8'd0;
            lat_write <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && selected && !enable) begin
                lat_addr  <= addr;
                lat_wdata <= wdata;
                lat_write <= write;
                wait_cnt  <= wait_reg;
            end else if (state == ACCESS && selected && wait_cnt != 8'd0) begin
                wait_cnt <= wait_cnt - 8'd1;
            end
            // A wait_reg update here only reaches the next transfer's wait_cnt.
            if (ready && lat_write) begin
                if (in_range)     mem[mem_idx] <= lat_wdata;
                else if (is_wait) wait_reg     <= lat_wdata;
            end
        end
    end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: scenario tasks compare DUT transfers against a
// behavioural register-file model (array + wait count) kept in this module.
module tb_apb_slave_regfile;
    localparam logic [1:0] SEL_ID    = 2'd1;
    localparam int         DEPTH     = 16;
    localparam logic [7:0] WAIT_ADDR = 8'hFF;
    localparam int         MAX_CYC   = 300;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel;
    logic       enable;
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ready;
    logic       err;
    logic [1:0] state_dbg;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] ref_mem [256];
    int         ref_wait;

    apb_slave_regfile #(
        .SEL_ID(SEL_ID), .DEPTH(DEPTH), .WAIT_ADDR(WAIT_ADDR), .WAIT_RESET(8'd0)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .enable(enable), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Reference model: a transfer costs (wait count + 2) cycles counted from the
    // first cycle after setup is sampled; effects land after the outputs are read.
    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
        ref_wait = 0;
    endtask

    task automatic model_xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                              output int exp_cyc, output logic [7:0] exp_rd,
                              output logic exp_er);
        logic valid;
        valid   = (int'(a) < DEPTH) || (a == WAIT_ADDR);
        exp_cyc = ref_wait + 2;
        exp_er  = !valid;
        if (int'(a) < DEPTH)    exp_rd = ref_mem[a];
        else if (a == WAIT_ADDR) exp_rd = 8'(ref_wait);
        else                     exp_rd = 8'hFF;
        if (wr) begin
            if (int'(a) < DEPTH)     ref_mem[a] = d;
            else if (a == WAIT_ADDR) ref_wait = int'(d);
        end
    endtask

    // Driver: setup cycle, then enable held until ready (bounded). Returns at the
    // negedge of the ready cycle so a following call is back-to-back.
    task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                            input logic scramble, output int cyc,
                            output logic [7:0] rd, output logic er);
        logic done;
        @(posedge clk); #1;
        sel = SEL_ID; enable = 1'b0; write = wr; addr = a; wdata = d;
        @(posedge clk); #1;
        enable = 1'b1;
        cyc = 0; rd = 8'd0; er = 1'b0; done = 1'b0;
        while (!done && cyc < MAX_CYC) begin
            cyc++;
            @(negedge clk);
            if (ready) begin
                rd = rdata; er = err; done = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (scramble) begin
                    addr = 8'($urandom); wdata = 8'($urandom); write = 1'($urandom);
                end
            end
        end
    endtask

    task automatic bus_idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            sel = 2'd0; enable = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sel = 2'd0; enable = 1'b0; write = 1'b0; addr = 8'd0; wdata = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_checks++;
        if (rdata !== 8'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        int cyc, ecyc; logic [7:0] rd, erd; logic er, eer;
        model_xfer(1'b1, 8'd6, 8'd5, ecyc, erd, eer);
        apb_xfer(1'b1, 8'd6, 8'd5, 1'b0, cyc, rd, er);
        n_checks++;
        if (cyc !== ecyc) begin n_fail++; $display("FAIL basic_wr_latency: got %0d expected %0d", cyc, ecyc); end
        n_checks++;
        if (er !== eer) begin n_fail++; $display("FAIL basic_wr_err: got %b expected %b", er, eer); end
        bus_idle(1);
        model_xfer(1'b0, 8'd6, 8'd0, ecyc, erd, eer);
        apb_xfer(1'b0, 8'd6, 8'd0, 1'b0, cyc, rd, er);
        n_checks++;
        if (cyc !== ecyc) begin n_fail++; $display("FAIL basic_rd_latency: got %0d expected %0d", cyc, ecyc); end
        n_checks++;
        if (rd !== erd) begin n_fail++; $display("FAIL basic_rd_data: got %h expected %h", rd, erd); end
        bus_idle(1);
        @(negedge clk);
        n_checks++;
        if (rdata !== 8'd0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL basic_rd_after: got rdata=%h ready=%b expected 00/0", rdata, ready);
        end
    endtask

    task automatic test_wait_states();
        int cyc, ecyc; logic [7:0] rd, erd; logic er, eer;
        logic       wr_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] a_t  [4] = '{WAIT_ADDR, 8'd5, 8'd5, WAIT_ADDR};
        logic [7:0] d_t  [4] = '{8'd5, 8'd4, 8'd0, 8'd0};
        for (int i = 0; i < 4; i++) begin
            model_xfer(wr_t[i], a_t[i], d_t[i], ecyc, erd, eer);
            apb_xfer(wr_t[i], a_t[i], d_t[i], 1'b1, cyc, rd, er);
            n_checks++;
            if (cyc !== ecyc || er !== eer || (!wr_t[i] && rd !== erd)) begin
                n_fail++;
                $display("FAIL wait_states[%0d]: got cyc=%0d rd=%h err=%b expected cyc=%0d rd=%h err=%b",
                         i, cyc, rd, er, ecyc, erd, eer);
            end
        end
        bus_idle(1);
    endtask

    task automatic test_out_of_range();
        int cyc, ecyc; logic [7:0] rd, erd; logic er, eer;
        logic       wr_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] a_t  [4] = '{WAIT_ADDR, 8'd20, 8'd20, 8'd20};
        logic [7:0] d_t  [4] = '{8'd1, 8'd0, 8'h77, 8'd0};
        for (int i = 0; i < 4; i++) begin
            model_xfer(wr_t[i], a_t[i], d_t[i], ecyc, erd, eer);
            apb_xfer(wr_t[i], a_t[i], d_t[i], 1'b0, cyc, rd, er);
            n_checks++;
            if (cyc !== ecyc || er !== eer || (!wr_t[i] && rd !== erd)) begin
                n_fail++;
                $display("FAIL out_of_range[%0d]: got cyc=%0d rd=%h err=%b expected cyc=%0d rd=%h err=%b",
                         i, cyc, rd, er, ecyc, erd, eer);
            end
        end
        for (int a = 0; a < DEPTH; a++) begin
            model_xfer(1'b0, 8'(a), 8'd0, ecyc, erd, eer);
            apb_xfer(1'b0, 8'(a), 8'd0, 1'b0, cyc, rd, er);
            n_checks++;
            if (cyc !== ecyc || rd !== erd || er !== 1'b0) begin
                n_fail++;
                $display("FAIL oor_readback[%0d]: got cyc=%0d rd=%h err=%b expected cyc=%0d rd=%h err=0",
                         a, cyc, rd, er, ecyc, erd);
            end
        end
        bus_idle(1);
    endtask

    task automatic test_no_select();
        int cyc, ecyc; logic [7:0] rd, erd; logic er, eer; int seen;
        seen = 0;
        @(posedge clk); #1;
        sel = 2'd2; enable = 1'b0; write = 1'b1; addr = 8'd3; wdata = 8'hC3;
        @(negedge clk);
        seen += int'(ready);
        @(posedge clk); #1;
        enable = 1'b1;
        repeat (4) begin @(negedge clk); seen += int'(ready); @(posedge clk); #1; end
        // Access phase without a preceding setup is ignored.
        sel = SEL_ID; enable = 1'b1; write = 1'b1; addr = 8'd3; wdata = 8'h3C;
        repeat (3) begin @(negedge clk); seen += int'(ready); @(posedge clk); #1; end
        sel = 2'd0; enable = 1'b0;
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL no_select_ready: got %0d ready cycles expected 0", seen); end
        model_xfer(1'b0, 8'd3, 8'd0, ecyc, erd, eer);
        apb_xfer(1'b0, 8'd3, 8'd0, 1'b0, cyc, rd, er);
        n_checks++;
        if (cyc !== ecyc || rd !== erd) begin
            n_fail++; $display("FAIL no_select_readback: got cyc=%0d rd=%h expected cyc=%0d rd=%h", cyc, rd, ecyc, erd);
        end
        bus_idle(1);
    endtask

    task automatic test_abort();
        int cyc, ecyc; logic [7:0] rd, erd; logic er, eer; int seen;
        model_xfer(1'b1, WAIT_ADDR, 8'd3, ecyc, erd, eer);
        apb_xfer(1'b1, WAIT_ADDR, 8'd3, 1'b0, cyc, rd, er);
        n_checks++;
        if (cyc !== ecyc) begin n_fail++; $display("FAIL abort_cfg_latency: got %0d expected %0d", cyc, ecyc); end
        seen = 0;
        @(posedge clk); #1;
        sel = SEL_ID; enable = 1'b0; write = 1'b1; addr = 8'd3; wdata = 8'hAB;
        @(posedge clk); #1;
        enable = 1'b1;
        repeat (2) begin @(negedge clk); seen += int'(ready); @(posedge clk); #1; end
        sel = 2'd0;
        @(negedge clk); seen += int'(ready);
        @(posedge clk); #1;
        enable = 1'b0;
        // Abort out of the setup cycle as well.
        @(posedge clk); #1;
        sel = SEL_ID; enable = 1'b0; write = 1'b1; addr = 8'd3; wdata = 8'hCD;
        @(posedge clk); #1;
        sel = 2'd0;
        repeat (2) begin @(negedge clk); seen += int'(ready); @(posedge clk); #1; end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_ready: got %0d ready cycles expected 0", seen); end
        for (int i = 0; i < 2; i++) begin
            logic [7:0] a;
            a = (i == 0) ? 8'd3 : WAIT_ADDR;
            model_xfer(1'b0, a, 8'd0, ecyc, erd, eer);
            apb_xfer(1'b0, a, 8'd0, 1'b0, cyc, rd, er);
            n_checks++;
            if (cyc !== ecyc || rd !== erd) begin
                n_fail++; $display("FAIL abort_readback[%0d]: got cyc=%0d rd=%h expected cyc=%0d rd=%h", i, cyc, rd, ecyc, erd);
            end
        end
        bus_idle(1);
    endtask

    task automatic test_back_to_back();
        int cyc, ecyc; logic [7:0] rd, erd; logic er, eer;
        logic wr; logic [7:0] a, d;
        for (int i = 0; i < 10; i++) begin
            wr = (i == 0) ? 1'b1 : 1'(i % 2);
            a  = (i == 0) ? WAIT_ADDR : 8'($urandom_range(0, DEPTH - 1));
            d  = (i == 0) ? 8'd0 : 8'($urandom);
            model_xfer(wr, a, d, ecyc, erd, eer);
            apb_xfer(wr, a, d, 1'b0, cyc, rd, er);
            n_checks++;
            if (cyc !== ecyc || er !== eer || (!wr && rd !== erd)) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got cyc=%0d rd=%h err=%b expected cyc=%0d rd=%h err=%b",
                         i, cyc, rd, er, ecyc, erd, eer);
            end
        end
        bus_idle(1);
    endtask

    task automatic test_max_wait();
        int cyc, ecyc; logic [7:0] rd, erd; logic er, eer;
        logic       wr_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] a_t  [4] = '{WAIT_ADDR, 8'd0, WAIT_ADDR, WAIT_ADDR};
        logic [7:0] d_t  [4] = '{8'd255, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 4; i++) begin
            model_xfer(wr_t[i], a_t[i], d_t[i], ecyc, erd, eer);
            apb_xfer(wr_t[i], a_t[i], d_t[i], 1'b0, cyc, rd, er);
            n_checks++;
            if (cyc !== ecyc || (!wr_t[i] && rd !== erd)) begin
                n_fail++;
                $display("FAIL max_wait[%0d]: got cyc=%0d rd=%h expected cyc=%0d rd=%h", i, cyc, rd, ecyc, erd);
            end
        end
        bus_idle(1);
    endtask

    task automatic test_random();
        int cyc, ecyc; logic [7:0] rd, erd; logic er, eer;
        logic wr; logic [7:0] a, d; int r;
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            wr = 1'($urandom);
            d  = 8'($urandom);
            if (r < 6)      a = 8'($urandom_range(0, DEPTH - 1));
            else if (r < 8) begin a = WAIT_ADDR; d = 8'($urandom_range(0, 3)); end
            else            a = 8'($urandom_range(DEPTH, 254));
            model_xfer(wr, a, d, ecyc, erd, eer);
            apb_xfer(wr, a, d, 1'b1, cyc, rd, er);
            n_checks++;
            if (cyc !== ecyc || er !== eer || (!wr && rd !== erd)) begin
                n_fail++;
                $display("FAIL random[%0d] wr=%b addr=%h: got cyc=%0d rd=%h err=%b expected cyc=%0d rd=%h err=%b",
                         i, wr, a, cyc, rd, er, ecyc, erd, eer);
            end
            bus_idle($urandom_range(0, 2));
        end
        bus_idle(1);
    endtask

    task automatic test_reset_midflight();
        int cyc, ecyc; logic [7:0] rd, erd; logic er, eer; logic [7:0] a;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? 8'd3 : WAIT_ADDR;
            model_xfer(1'b1, a, (i == 0) ? 8'h11 : 8'd10, ecyc, erd, eer);
            apb_xfer(1'b1, a, (i == 0) ? 8'h11 : 8'd10, 1'b0, cyc, rd, er);
        end
        @(posedge clk); #1;
        sel = SEL_ID; enable = 1'b0; write = 1'b1; addr = 8'd3; wdata = 8'h5A;
        @(posedge clk); #1;
        enable = 1'b1;
        repeat (3) @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; sel = 2'd0; enable = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0 || rdata !== 8'd0 || err !== 1'b0) begin
            n_fail++; $display("FAIL midflight_outputs: got ready=%b rdata=%h err=%b expected 0/00/0", ready, rdata, err);
        end
        for (int i = 0; i <= DEPTH; i++) begin
            a = (i == DEPTH) ? WAIT_ADDR : 8'(i);
            model_xfer(1'b0, a, 8'd0, ecyc, erd, eer);
            apb_xfer(1'b0, a, 8'd0, 1'b0, cyc, rd, er);
            n_checks++;
            if (cyc !== ecyc || rd !== erd) begin
                n_fail++; $display("FAIL midflight_readback[%0d]: got cyc=%0d rd=%h expected cyc=%0d rd=%h", i, cyc, rd, ecyc, erd);
            end
        end
        bus_idle(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_out_of_range();
        test_no_select();
        test_abort();
        test_back_to_back();
        test_max_wait();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
